// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 timer block.
package chip8_pkg;

    localparam int unsigned CLK_HZ           = 4857480;
    localparam int unsigned TIMER_HZ         = 60;
    localparam int unsigned TIMER_W          = 8;
    localparam int unsigned DEFAULT_TONE_DIV = 5520;

    // Wide enough for the largest legal TONE_DIV (8191).
    localparam int unsigned TONE_CNT_W       = 13;

    typedef logic [7:0] timer_t;

endpackage

// File: rtl/chip8_countdown.sv
// One load / decrement-to-zero register, used for both DT and ST.
module chip8_countdown
    import chip8_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         tick,
    output logic [W-1:0] value
);

    logic [W-1:0] value_d, value_q;

    // Load beats tick; decrement saturates at zero.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = loadVal;
        end else if (tick && (value_q != '0)) begin
            value_d = value_q - 1'b1;
        end
    end

    // Counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/chip8_timers.sv
// CHIP-8 delay and sound timers with a square-wave beeper.
module chip8_timers
#(
    parameter int unsigned TONE_DIV = chip8_pkg::DEFAULT_TONE_DIV,
    parameter int unsigned TIMER_W  = chip8_pkg::TIMER_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               timerClk,
    input  logic               dtWrite,
    input  logic               stWrite,
    input  logic [TIMER_W-1:0] wrData,
    output logic [TIMER_W-1:0] dtValue,
    output logic [TIMER_W-1:0] stValue,
    output logic               soundOn,
    output logic               speaker,
    output logic               timerTick
);

    import chip8_pkg::*;

    localparam logic [TONE_CNT_W-1:0] ToneLast = TONE_CNT_W'(TONE_DIV - 1);

    logic                  prev_timer_d, prev_timer_q;
    logic                  timer_tick_d, timer_tick_q;
    logic [TONE_CNT_W-1:0] tone_cnt_d, tone_cnt_q;
    logic                  speaker_d, speaker_q;
    logic                  tick;
    logic                  sound_on;

    // Rising-edge detect; prev starts high so a level already high at reset release is ignored.
    always_comb begin
        tick         = timerClk & ~prev_timer_q;
        prev_timer_d = timerClk;
        timer_tick_d = tick;
    end

    chip8_countdown #(
        .W (TIMER_W)
    ) u_dt (
        .clk     (clk),
        .reset   (reset),
        .load    (dtWrite),
        .loadVal (wrData),
        .tick    (tick),
        .value   (dtValue)
    );

    chip8_countdown #(
        .W (TIMER_W)
    ) u_st (
        .clk     (clk),
        .reset   (reset),
        .load    (stWrite),
        .loadVal (wrData),
        .tick    (tick),
        .value   (stValue)
    );

    assign sound_on = (stValue != '0);

    // Tone divider; a reload of a non-zero ST keeps the running phase.
    always_comb begin
        tone_cnt_d = tone_cnt_q;
        speaker_d  = speaker_q;
        if (!sound_on) begin
            tone_cnt_d = '0;
            speaker_d  = 1'b0;
        end else if (tone_cnt_q == ToneLast) begin
            tone_cnt_d = '0;
            speaker_d  = ~speaker_q;
        end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
        end
    end

    // Edge-detect, tick pulse and tone state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_timer_q <= 1'b1;
            timer_tick_q <= 1'b0;
            tone_cnt_q   <= '0;
            speaker_q    <= 1'b0;
        end else begin
            prev_timer_q <= prev_timer_d;
            timer_tick_q <= timer_tick_d;
            tone_cnt_q   <= tone_cnt_d;
            speaker_q    <= speaker_d;
        end
    end

    assign soundOn   = sound_on;
    assign speaker   = speaker_q;
    assign timerTick = timer_tick_q;

endmodule

// File: tb/tb_chip8_timers.sv
// Directed self-checking bench for chip8_timers (TONE_DIV = 4).
module tb_chip8_timers;

    logic       clk;
    logic       reset;
    logic       timerClk;
    logic       dtWrite;
    logic       stWrite;
    logic [7:0] wrData;
    logic [7:0] dtValue;
    logic [7:0] stValue;
    logic       soundOn;
    logic       speaker;
    logic       timerTick;

    int vectors;
    int miscompares;
    int tick_cnt;

    chip8_timers #(
        .TONE_DIV (4),
        .TIMER_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .timerClk  (timerClk),
        .dtWrite   (dtWrite),
        .stWrite   (stWrite),
        .wrData    (wrData),
        .dtValue   (dtValue),
        .stValue   (stValue),
        .soundOn   (soundOn),
        .speaker   (speaker),
        .timerTick (timerTick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_dt [4];
        exp_dt = '{8'd2, 8'd1, 8'd0, 8'd0};
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b1;
        timerClk = 1'b1;
        dtWrite  = 1'b0;
        stWrite  = 1'b0;
        wrData   = 8'd0;

        // Reset state, then release with timerClk already high.
        repeat (3) cyc();
        check("rst_dt", 32'(dtValue), 0);
        check("rst_st", 32'(stValue), 0);
        check("rst_spk", 32'(speaker), 0);
        check("rst_tick", 32'(timerTick), 0);
        reset    = 1'b0;
        tick_cnt = 0;
        repeat (100) begin
            cyc();
            if (timerTick) tick_cnt++;
        end
        check("hi_rel_ticks", 32'(tick_cnt), 0);
        check("hi_rel_dt", 32'(dtValue), 0);
        check("hi_rel_spk", 32'(speaker), 0);
        timerClk = 1'b0;
        cyc();

        // Load DT=3 and run four ticks.
        dtWrite = 1'b1;
        wrData  = 8'd3;
        cyc();
        dtWrite = 1'b0;
        check("dt_load3", 32'(dtValue), 3);
        for (int i = 0; i < 4; i++) begin
            timerClk = 1'b1;
            cyc();
            check("dt_dec", 32'(dtValue), 32'(exp_dt[i]));
            check("tick_pulse", 32'(timerTick), 1);
            timerClk = 1'b0;
            cyc();
            check("tick_low", 32'(timerTick), 0);
        end

        // Write coinciding with a tick wins.
        dtWrite = 1'b1;
        wrData  = 8'd5;
        cyc();
        check("dt_load5", 32'(dtValue), 5);
        timerClk = 1'b1;
        wrData   = 8'd9;
        cyc();
        dtWrite = 1'b0;
        check("dt_wr_vs_tick", 32'(dtValue), 9);
        timerClk = 1'b0;
        cyc();
        timerClk = 1'b1;
        cyc();
        check("dt_after_wr", 32'(dtValue), 8);
        timerClk = 1'b0;
        cyc();

        // Sound: ST=2, speaker toggles every 4 cycles, silence after 2 ticks.
        stWrite = 1'b1;
        wrData  = 8'd2;
        cyc();
        stWrite = 1'b0;
        check("snd_on", 32'(soundOn), 1);
        check("st_load2", 32'(stValue), 2);
        check("spk_init", 32'(speaker), 0);
        repeat (3) cyc();
        check("spk_pre_rise", 32'(speaker), 0);
        cyc();
        check("spk_rise", 32'(speaker), 1);
        repeat (3) cyc();
        check("spk_hold_hi", 32'(speaker), 1);
        cyc();
        check("spk_fall", 32'(speaker), 0);
        repeat (4) cyc();
        check("spk_rise2", 32'(speaker), 1);
        timerClk = 1'b1;
        cyc();
        check("st_dec1", 32'(stValue), 1);
        timerClk = 1'b0;
        cyc();
        timerClk = 1'b1;
        cyc();
        check("st_dec0", 32'(stValue), 0);
        check("snd_off", 32'(soundOn), 0);
        check("dt_side_ticks", 32'(dtValue), 6);
        timerClk = 1'b0;
        cyc();
        check("spk_off", 32'(speaker), 0);

        // Reloading ST while sounding keeps the tone phase; writing 0 silences.
        stWrite = 1'b1;
        wrData  = 8'd50;
        cyc();
        stWrite = 1'b0;
        repeat (2) cyc();
        stWrite = 1'b1;
        wrData  = 8'd40;
        cyc();
        stWrite = 1'b0;
        check("st_reload", 32'(stValue), 40);
        cyc();
        check("spk_phase_kept", 32'(speaker), 1);
        stWrite = 1'b1;
        wrData  = 8'd0;
        cyc();
        stWrite = 1'b0;
        check("st_zero_snd", 32'(soundOn), 0);
        cyc();
        check("st_zero_spk", 32'(speaker), 0);

        // Long timerClk high: exactly one decrement and one pulse.
        dtWrite = 1'b1;
        wrData  = 8'd10;
        cyc();
        dtWrite  = 1'b0;
        timerClk = 1'b1;
        tick_cnt = 0;
        repeat (500) begin
            cyc();
            if (timerTick) tick_cnt++;
        end
        check("long_hi_ticks", 32'(tick_cnt), 1);
        check("long_hi_dt", 32'(dtValue), 9);
        timerClk = 1'b0;
        cyc();

        // Asynchronous reset mid-tone.
        dtWrite = 1'b1;
        stWrite = 1'b1;
        wrData  = 8'd200;
        cyc();
        dtWrite = 1'b0;
        stWrite = 1'b0;
        repeat (6) cyc();
        check("pre_rst_spk", 32'(speaker), 1);
        #2;
        reset    = 1'b1;
        timerClk = 1'b1;
        #1;
        check("arst_dt", 32'(dtValue), 0);
        check("arst_st", 32'(stValue), 0);
        check("arst_snd", 32'(soundOn), 0);
        check("arst_spk", 32'(speaker), 0);
        check("arst_tick", 32'(timerTick), 0);
        cyc();
        reset   = 1'b0;
        dtWrite = 1'b1;
        wrData  = 8'd200;
        cyc();
        dtWrite  = 1'b0;
        tick_cnt = 0;
        repeat (20) begin
            cyc();
            if (timerTick) tick_cnt++;
        end
        check("post_rst_hold", 32'(dtValue), 200);
        check("post_rst_ticks", 32'(tick_cnt), 0);
        timerClk = 1'b0;
        cyc();
        timerClk = 1'b1;
        cyc();
        check("post_rst_dec", 32'(dtValue), 199);
        timerClk = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
